// File: rtl/sram_like_responder_pkg.sv
//==============================================================================
// Module : sram_like_responder_pkg
// Brief  : Shared constants and byte-merge helper for the sram-like responder.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package sram_like_responder_pkg;

    // Transfer size encodings carried on the size port (informational only).
    localparam logic [1:0] SRAM_SIZE_B  = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H  = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W  = 2'd2;
    localparam int         SRAM_DATA_WD = 32;

    // Replace the byte lanes of old_word selected by strb with the lanes of new_word.
    function automatic logic [SRAM_DATA_WD-1:0] merge_bytes(
        input logic [SRAM_DATA_WD-1:0] old_word,
        input logic [SRAM_DATA_WD-1:0] new_word,
        input logic [3:0]              strb
    );
        logic [SRAM_DATA_WD-1:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_responder_resp_queue.sv
//==============================================================================
// Module : sram_like_responder_resp_queue
// Brief  : In-order response FIFO. Each entry carries is_wr, read data and a
//          wait counter that gates when the entry may be answered.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sram_like_responder_resp_queue
    import sram_like_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    push_is_wr_i,
    input  logic [SRAM_DATA_WD-1:0] push_data_i,
    input  logic                    pop_i,
    output logic                    head_valid_o,
    output logic                    head_ready_o,
    output logic                    head_is_wr_o,
    output logic [SRAM_DATA_WD-1:0] head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [WCW-1:0] WAIT_INIT = WCW'(LAT - 1);
    localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);

    logic                    is_wr_q [DEPTH];
    logic [SRAM_DATA_WD-1:0] data_q  [DEPTH];
    logic [WCW-1:0]          wait_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Pointers wrap at DEPTH (which need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Next-state for pointers and occupancy; push and pop may coincide.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset drops any in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload and wait counters; stale slots are harmless as count gates validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_ptr_q == PW'(i))) begin
                is_wr_q[i] <= push_is_wr_i;
                data_q[i]  <= push_data_i;
                wait_q[i]  <= WAIT_INIT;
            end else if (wait_q[i] != '0) begin
                wait_q[i]  <= wait_q[i] - WCW'(1);
            end
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_ready_o = head_valid_o && (wait_q[rd_ptr_q] == '0);
    assign head_is_wr_o = is_wr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

`default_nettype wire

// File: rtl/sram_like_responder.sv
//==============================================================================
// Module : sram_like_responder
// Brief  : Slave end of the sram-like req/addr_ok/data_ok interface with a
//          word-addressed backing RAM and up to DEPTH outstanding requests.
//          Optional macro SRAM_RAND_STALL_EN adds LFSR-driven random stalls
//          on both addr_ok and data_ok.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int          MEM_AW    = 16,
    parameter int          DEPTH     = 2,
    parameter int          LAT       = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [SRAM_DATA_WD-1:0] mem_q [2**MEM_AW];

    logic [MEM_AW-1:0]       w_idx;
    logic                    w_push;
    logic                    w_head_ready;
    logic                    w_head_is_wr;
    logic [SRAM_DATA_WD-1:0] w_head_data;
    logic [SRAM_DATA_WD-1:0] w_push_data;
    logic [CW-1:0]           w_count;
    logic                    w_stall_acc;
    logic                    w_stall_rsp;

    // Upper address bits simply alias (wrap); byte offset and size do not select lanes.
    assign w_idx = addr[MEM_AW+1:2];

`ifdef SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Free-running stall pattern generator, restarted from the seed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_stall_acc = lfsr_q[0];
    assign w_stall_rsp = lfsr_q[1];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign w_stall_acc = 1'b0;
    assign w_stall_rsp = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{size, addr[1:0], addr[31:MEM_AW+2]};

    // Full check uses the registered count only: no pop bypass, no req dependency.
    assign addr_ok = ~reset && (w_count < DEPTH_C) && ~w_stall_acc;
    assign w_push  = req && addr_ok;

    assign data_ok = ~reset && w_head_ready && ~w_stall_rsp;
    assign rdata   = (data_ok && !w_head_is_wr) ? w_head_data : '0;

    // Reads capture the RAM word at the handshake edge, so earlier writes are visible.
    assign w_push_data = wr ? '0 : mem_q[w_idx];

    // Byte-enabled RAM write at the handshake edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_push && wr) begin
            mem_q[w_idx] <= merge_bytes(mem_q[w_idx], wdata, wstrb);
        end
    end

    sram_like_responder_resp_queue #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) u_resp_queue (
        .clk          (clk),
        .rst          (reset),
        .push_i       (w_push),
        .push_is_wr_i (wr),
        .push_data_i  (w_push_data),
        .pop_i        (data_ok),
        .head_valid_o (),
        .head_ready_o (w_head_ready),
        .head_is_wr_o (w_head_is_wr),
        .head_data_o  (w_head_data),
        .count_o      (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_sram_like_responder.sv
//==============================================================================
// Module : tb_sram_like_responder
// Brief  : Scoreboard bench for sram_like_responder. Instance A uses
//          MEM_AW=4/DEPTH=2/LAT=1, instance B uses MEM_AW=8/DEPTH=2/LAT=3.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_sram_like_responder;

    logic        clk;
    logic        reset   [2];
    logic        req     [2];
    logic        wr      [2];
    logic [1:0]  size    [2];
    logic [3:0]  wstrb   [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    int n_vec;
    int n_err;

    sram_like_responder #(.MEM_AW(4), .DEPTH(2), .LAT(1), .LFSR_SEED(16'hACE1)) u_dut_a (
        .clk(clk), .reset(reset[0]), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]),
        .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
    );

    sram_like_responder #(.MEM_AW(8), .DEPTH(2), .LAT(3), .LFSR_SEED(16'hACE1)) u_dut_b (
        .clk(clk), .reset(reset[1]), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]),
        .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int inst, input logic [31:0] e);
        if (inst == 0) exp_q0.push_back(e);
        else           exp_q1.push_back(e);
    endtask

    function automatic int q_size(input int inst);
        return (inst == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Monitor: every data_ok must match the oldest outstanding expectation.
    task automatic mon(input int inst);
        logic [31:0] e;
        if (data_ok[inst] === 1'b1) begin
            if (q_size(inst) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_data_ok inst%0d: got rdata %h, expected no response", inst, rdata[inst]);
            end else begin
                e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("rdata_inst%0d", inst), rdata[inst], e);
            end
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic drive(input int inst, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req[inst]   = 1'b1;
        wr[inst]    = w;
        size[inst]  = 2'd2;
        wstrb[inst] = s;
        addr[inst]  = a;
        wdata[inst] = d;
    endtask

    task automatic idle(input int inst);
        req[inst]   = 1'b0;
        wr[inst]    = 1'b0;
        wstrb[inst] = 4'h0;
    endtask

    // Present one request until accepted; e is the response the scoreboard expects.
    task automatic issue(input int inst, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        bit done;
        done = 1'b0;
        drive(inst, w, s, a, d);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (addr_ok[inst] === 1'b1) begin
                push_exp(inst, e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout inst%0d: got no addr_ok, expected accept of addr %h", inst, a);
        end
        idle(inst);
    endtask

    task automatic drain(input int inst);
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 200 && !empty; k++) begin
            @(posedge clk);
            #1;
            if (q_size(inst) == 0) empty = 1'b1;
        end
        if (!empty) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout inst%0d: got %0d pending, expected 0", inst, q_size(inst));
        end
    endtask

`ifdef SRAM_RAND_STALL_EN
    logic [31:0] mdl [16];

    task automatic random_test();
        logic [31:0] a, d, e;
        logic [3:0]  s;
        logic        w;
        int          idx;
        for (int i = 0; i < 16; i++) begin
            d = $urandom();
            mdl[i] = d;
            issue(0, 1'b1, 4'hF, 32'(i) << 2, d, 32'h0);
        end
        for (int n = 0; n < 1000; n++) begin
            w   = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            s   = 4'($urandom_range(0, 15));
            d   = $urandom();
            a   = ($urandom() & 32'hFFFF_FFC0) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
                end
                e = 32'h0;
            end else begin
                e = mdl[idx];
            end
            issue(0, w, s, a, d, e);
        end
        drain(0);
    endtask
`endif

    // Test 3 expectations, cycle by cycle from the first held request.
    logic        t3_aok [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t3_dok [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t3_addr[3] = '{32'h20, 32'h24, 32'h28};
    logic [31:0] t3_data[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    initial begin
        int acc;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            size[i]  = 2'd0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            idle(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_addr_ok", 32'(addr_ok[0]), 32'd0);
        chk("rst_data_ok", 32'(data_ok[0]), 32'd0);
        chk("rst_rdata",   rdata[0],        32'd0);
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;

`ifndef SRAM_RAND_STALL_EN
        @(negedge clk);
        chk("post_rst_addr_ok", 32'(addr_ok[0]), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: write then read next cycle -> two consecutive responses
        drive(0, 1'b1, 4'hF, 32'h1C00_0000, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_wr_addr_ok", 32'(addr_ok[0]), 32'd1);
        push_exp(0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0);
        @(negedge clk);
        chk("t1_wr_data_ok", 32'(data_ok[0]), 32'd1);
        chk("t1_rd_addr_ok", 32'(addr_ok[0]), 32'd1);
        push_exp(0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        idle(0);
        @(negedge clk);
        chk("t1_rd_data_ok", 32'(data_ok[0]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_idle_data_ok", 32'(data_ok[0]), 32'd0);
        @(posedge clk);
        #1;
`else
        issue(0, 1'b1, 4'hF, 32'h1C00_0000, 32'hDEAD_BEEF, 32'h0);
        issue(0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0, 32'hDEAD_BEEF);
        drain(0);
`endif

        // Test 2: byte-lane write merge
        issue(0, 1'b1, 4'hF,    32'h10, 32'h1122_3344, 32'h0);
        issue(0, 1'b1, 4'b0010, 32'h10, 32'h0000_AB00, 32'h0);
        issue(0, 1'b0, 4'h0,    32'h10, 32'h0,         32'h1122_AB44);
        drain(0);

        // Test 3 preload on the LAT=3 instance
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b1, 4'hF, t3_addr[i], t3_data[i], 32'h0);
        end
        drain(1);

`ifndef SRAM_RAND_STALL_EN
        // Test 3: req held, addr_ok drops when two are outstanding
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 5 && acc < 3) drive(1, 1'b0, 4'h0, t3_addr[acc], 32'h0);
            else                  idle(1);
            @(negedge clk);
            chk($sformatf("t3_addr_ok_c%0d", k), 32'(addr_ok[1]), 32'(t3_aok[k]));
            chk($sformatf("t3_data_ok_c%0d", k), 32'(data_ok[1]), 32'(t3_dok[k]));
            if (req[1] && addr_ok[1]) begin
                push_exp(1, t3_data[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        idle(1);
        chk("t3_accepts", 32'(acc), 32'd3);
        drain(1);

        // Test 4: reset right after a read handshake drops it
        drive(0, 1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t4_addr_ok", 32'(addr_ok[0]), 32'd1);
        @(posedge clk);
        #1;
        idle(0);
        reset[0] = 1'b1;
        @(negedge clk);
        chk("t4_rst_addr_ok", 32'(addr_ok[0]), 32'd0);
        chk("t4_rst_data_ok", 32'(data_ok[0]), 32'd0);
        chk("t4_rst_rdata",   rdata[0],        32'd0);
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        @(negedge clk);
        chk("t4_after_addr_ok", 32'(addr_ok[0]), 32'd1);
        chk("t4_after_data_ok", 32'(data_ok[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
`else
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b0, 4'h0, t3_addr[i], 32'h0, t3_data[i]);
        end
        drain(1);
`endif

        // Test 5: address wrap with MEM_AW=4, byte offset ignored
        issue(0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D, 32'h0);
        issue(0, 1'b0, 4'h0, 32'h00, 32'h0, 32'hCAFE_F00D);
        issue(0, 1'b0, 4'h0, 32'h43, 32'h0, 32'hCAFE_F00D);
        drain(0);

`ifdef SRAM_RAND_STALL_EN
        random_test();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("end_pending_a", 32'(exp_q0.size()), 32'd0);
        chk("end_pending_b", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
